univ_shift_reg: RTL



---
 rtl/univ_shift_reg_if.sv | 24 ++
 rtl/univ_shift_reg.sv | 92 +++++++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - control, data and status bundle for the universal shift register
// The master drives the operation and serial inputs; the slave returns the register state.
interface univ_shift_reg_if #(
  parameter int W = 8
);
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] q;
  logic         cout;
  logic         zero;

  modport master (
    output en, mode, d, sin_r, sin_l,
    input  q, cout, zero
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l,
    output q, cout, zero
  );
endinterface

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - W-bit register with enable, load, clear and one-bit shifts/rotates
// Holds exactly q and a registered carry-out; zero is decoded from q alone.
module univ_shift_reg #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
  input  logic            clk,
  input  logic            reset_n,
  univ_shift_reg_if.slave bus
);

  if (W < 2 || W > 64) begin : g_bad_width
    $fatal(1, "univ_shift_reg: W must be in 2..64");
  end

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_SRA   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_ROR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  logic [W-1:0] q_r;
  logic         cout_r;
  logic [W-1:0] q_nxt;
  logic         cout_nxt;

  // Every shift reads the pre-edge q_r, so there is no path from q back into itself.
  always_comb begin
    q_nxt    = q_r;
    cout_nxt = cout_r;
    case (mode_e'(bus.mode))
      MODE_HOLD: begin
        q_nxt    = q_r;
        cout_nxt = cout_r;
      end
      MODE_LOAD: begin
        q_nxt    = bus.d;
      end
      MODE_SHL: begin
        q_nxt    = {q_r[W-2:0], bus.sin_r};
        cout_nxt = q_r[W-1];
      end
      MODE_SHR: begin
        q_nxt    = {bus.sin_l, q_r[W-1:1]};
        cout_nxt = q_r[0];
      end
      MODE_SRA: begin
        q_nxt    = {q_r[W-1], q_r[W-1:1]};
        cout_nxt = q_r[0];
      end
      MODE_ROL: begin
        q_nxt    = {q_r[W-2:0], q_r[W-1]};
        cout_nxt = q_r[W-1];
      end
      MODE_ROR: begin
        q_nxt    = {q_r[0], q_r[W-1:1]};
        cout_nxt = q_r[0];
      end
      MODE_CLEAR: begin
        q_nxt    = RESET_VAL;
        cout_nxt = 1'b0;
      end
      default: begin
        q_nxt    = q_r;
        cout_nxt = cout_r;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r    <= RESET_VAL;
      cout_r <= 1'b0;
    end else if (bus.en) begin
      q_r    <= q_nxt;
      cout_r <= cout_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.cout = cout_r;
  assign bus.zero = (q_r == '0);

  a_mode_known : assert property (@(posedge clk) disable iff (!reset_n)
    bus.en |-> !$isunknown(bus.mode));

endmodule
